// File: rtl/maze_pkg.sv
// Shared codes for the maze wall follower: move commands, headings, FSM states
// and the wall-following priority rule.
package maze_pkg;

  localparam int unsigned MOVE_W    = 3;
  localparam int unsigned HEADING_W = 2;

  typedef enum logic [MOVE_W-1:0] {
    MV_STOP  = 3'b000,
    MV_FWD   = 3'b001,
    MV_LEFT  = 3'b010,
    MV_RIGHT = 3'b011,
    MV_UTURN = 3'b100
  } move_e;

  typedef enum logic [HEADING_W-1:0] {
    HDG_N = 2'd0,
    HDG_E = 2'd1,
    HDG_S = 2'd2,
    HDG_W = 2'd3
  } hdg_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_FWD_AFTER_TURN,
    S_DONE,
    S_ERROR
  } state_e;

  // Preferred-side opening first, then straight, then the opposite side, else turn around.
  function automatic move_e pick_move(input logic hand, input logic left,
                                      input logic mid, input logic right);
    logic  pref;
    logic  opp;
    move_e res;
    pref = hand ? right : left;
    opp  = hand ? left : right;
    res  = MV_UTURN;
    if (!pref)     res = hand ? MV_RIGHT : MV_LEFT;
    else if (!mid) res = MV_FWD;
    else if (!opp) res = hand ? MV_LEFT : MV_RIGHT;
    return res;
  endfunction

endpackage

// File: rtl/maze_wall_follower_if.sv
// Sensor/start inputs and command/status outputs of the maze wall follower.
interface maze_wall_follower_if #(
  parameter int unsigned RW   = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned DE_W = 4
);
  logic            start;
  logic            left;
  logic            mid;
  logic            right;
  logic [2:0]      move;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [1:0]      heading;
  logic [DE_W-1:0] deadend_count;
  logic            done;
  logic            err;

  modport master (output start, left, mid, right,
                  input  move, row, col, heading, deadend_count, done, err);
  modport slave  (input  start, left, mid, right,
                  output move, row, col, heading, deadend_count, done, err);
endinterface

// File: rtl/maze_pos_tracker.sv
// Owns heading and grid position; exposes the cell a FORWARD would land on
// and whether that cell lies outside the grid.
module maze_pos_tracker
  import maze_pkg::*;
#(
  parameter int unsigned ROWS      = 9,
  parameter int unsigned COLS      = 9,
  parameter int unsigned START_ROW = 4,
  parameter int unsigned START_COL = 0,
  parameter int unsigned START_HDG = 1,
  parameter int unsigned RW        = 4,
  parameter int unsigned CW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  move_e         mv,
  input  logic          commit,
  output hdg_e          heading,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [RW-1:0] tgt_row,
  output logic [CW-1:0] tgt_col,
  output logic          off_grid
);

  // One-cell step along the heading; edge cells pointing outward flag off-grid.
  always_comb begin
    tgt_row  = row;
    tgt_col  = col;
    off_grid = 1'b0;
    unique case (heading)
      HDG_N: if (row == '0) off_grid = 1'b1; else tgt_row = row - RW'(1);
      HDG_S: if (row == RW'(ROWS - 1)) off_grid = 1'b1; else tgt_row = row + RW'(1);
      HDG_E: if (col == CW'(COLS - 1)) off_grid = 1'b1; else tgt_col = col + CW'(1);
      HDG_W: if (col == '0) off_grid = 1'b1; else tgt_col = col - CW'(1);
      default: off_grid = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      heading <= hdg_e'(2'(START_HDG));
      row     <= RW'(START_ROW);
      col     <= CW'(START_COL);
    end else if (commit) begin
      case (mv)
        MV_FWD: begin
          if (!off_grid) begin
            row <= tgt_row;
            col <= tgt_col;
          end
        end
        MV_LEFT:  heading <= hdg_e'(heading - 2'd1);
        MV_RIGHT: heading <= hdg_e'(heading + 2'd1);
        MV_UTURN: heading <= hdg_e'(heading + 2'd2);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/maze_wall_follower.sv
// Left/right-hand wall follower: issues one move per cycle, stops at the exit
// cell, and latches an error on an off-grid move or step-watchdog expiry.
module maze_wall_follower
  import maze_pkg::*;
#(
  parameter int unsigned ROWS      = 9,
  parameter int unsigned COLS      = 9,
  parameter int unsigned START_ROW = 4,
  parameter int unsigned START_COL = 0,
  parameter int unsigned START_HDG = 1,
  parameter int unsigned EXIT_ROW  = 4,
  parameter int unsigned EXIT_COL  = 8,
  parameter int unsigned HAND      = 0,
  parameter int unsigned DE_W      = 4,
  parameter int unsigned MAX_STEPS = 255
) (
  input logic                clk,
  input logic                rst,
  maze_wall_follower_if.slave bus
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS + 1) : 1;

  state_e        state;
  logic [SW-1:0] steps;
  move_e         cmd_c;
  logic          commit_c;
  logic          at_exit_c;
  logic          last_step_c;
  hdg_e          heading;
  logic [RW-1:0] tgt_row;
  logic [CW-1:0] tgt_col;
  logic          off_grid;

  maze_pos_tracker #(
    .ROWS(ROWS), .COLS(COLS), .START_ROW(START_ROW), .START_COL(START_COL),
    .START_HDG(START_HDG), .RW(RW), .CW(CW)
  ) u_pos (
    .clk(clk), .rst(rst), .mv(cmd_c), .commit(commit_c), .heading(heading),
    .row(bus.row), .col(bus.col), .tgt_row(tgt_row), .tgt_col(tgt_col),
    .off_grid(off_grid)
  );

  assign bus.heading = heading;
  assign at_exit_c   = (tgt_row == RW'(EXIT_ROW)) && (tgt_col == CW'(EXIT_COL));
  assign last_step_c = (steps == SW'(MAX_STEPS - 1));

  // Command for this cycle; a FORWARD into the grid boundary becomes STOP.
  always_comb begin
    cmd_c    = MV_STOP;
    commit_c = 1'b0;
    unique case (state)
      S_DECIDE: begin
        cmd_c    = pick_move(HAND != 0, bus.left, bus.mid, bus.right);
        commit_c = 1'b1;
      end
      S_FWD_AFTER_TURN: begin
        cmd_c    = MV_FWD;
        commit_c = 1'b1;
      end
      default: ;
    endcase
    if (cmd_c == MV_FWD && off_grid) cmd_c = MV_STOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      steps             <= '0;
      bus.move          <= MV_STOP;
      bus.deadend_count <= '0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bus.move <= MV_STOP;
          if (bus.start) state <= S_DECIDE;
        end
        S_DECIDE, S_FWD_AFTER_TURN: begin
          bus.move <= cmd_c;
          case (cmd_c)
            MV_STOP: begin
              bus.err <= 1'b1;
              state   <= S_ERROR;
            end
            MV_FWD: begin
              steps <= steps + SW'(1);
              // Exit wins over a simultaneous watchdog expiry.
              if (at_exit_c)        state <= S_DONE;
              else if (last_step_c) state <= S_ERROR;
              else                  state <= S_DECIDE;
            end
            default: begin
              if (cmd_c == MV_UTURN && bus.deadend_count != '1)
                bus.deadend_count <= bus.deadend_count + DE_W'(1);
              state <= S_FWD_AFTER_TURN;
            end
          endcase
        end
        S_DONE: begin
          bus.move <= MV_STOP;
          bus.done <= 1'b1;
        end
        S_ERROR: begin
          bus.move <= MV_STOP;
          bus.err  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_wall_follower.sv
// Self-checking bench: four follower configurations driven in lockstep and
// compared against an arithmetic grid-walk model, plus a directed vector table.
module tb_maze_wall_follower;

  localparam int NI = 4;
  // Per-instance configuration: default, right-hand, north-west corner, short watchdog.
  localparam int P_HAND [NI] = '{0, 1, 0, 0};
  localparam int P_SR   [NI] = '{4, 4, 0, 4};
  localparam int P_SC   [NI] = '{0, 0, 0, 0};
  localparam int P_SH   [NI] = '{1, 1, 0, 1};
  localparam int P_MAX  [NI] = '{255, 255, 255, 5};
  localparam int DR [4] = '{-1, 0, 1, 0};
  localparam int DC [4] = '{0, 1, 0, -1};
  localparam int DC_SAT = 15;

  localparam int MP_IDLE = 0, MP_DEC = 1, MP_TURN = 2, MP_EXIT = 3, MP_ERR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_d = 1'b0, l_d = 1'b0, m_d = 1'b0, r_d = 1'b0;
  always #5 clk = ~clk;

  maze_wall_follower_if #(.RW(4), .CW(4), .DE_W(4)) if0 ();
  maze_wall_follower_if #(.RW(4), .CW(4), .DE_W(4)) if1 ();
  maze_wall_follower_if #(.RW(4), .CW(4), .DE_W(4)) if2 ();
  maze_wall_follower_if #(.RW(4), .CW(4), .DE_W(4)) if3 ();

  assign if0.start = start_d; assign if0.left = l_d; assign if0.mid = m_d; assign if0.right = r_d;
  assign if1.start = start_d; assign if1.left = l_d; assign if1.mid = m_d; assign if1.right = r_d;
  assign if2.start = start_d; assign if2.left = l_d; assign if2.mid = m_d; assign if2.right = r_d;
  assign if3.start = start_d; assign if3.left = l_d; assign if3.mid = m_d; assign if3.right = r_d;

  maze_wall_follower u0 (.clk(clk), .rst(rst), .bus(if0));
  maze_wall_follower #(.HAND(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  maze_wall_follower #(.START_ROW(0), .START_COL(0), .START_HDG(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
  maze_wall_follower #(.MAX_STEPS(5)) u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [18:0] obs_v [NI];
  assign obs_v[0] = {if0.move, if0.row, if0.col, if0.heading, if0.deadend_count, if0.done, if0.err};
  assign obs_v[1] = {if1.move, if1.row, if1.col, if1.heading, if1.deadend_count, if1.done, if1.err};
  assign obs_v[2] = {if2.move, if2.row, if2.col, if2.heading, if2.deadend_count, if2.done, if2.err};
  assign obs_v[3] = {if3.move, if3.row, if3.col, if3.heading, if3.deadend_count, if3.done, if3.err};

  int n_chk = 0;
  int n_err = 0;

  int m_ph [NI], m_mv [NI], m_row [NI], m_col [NI], m_hdg [NI];
  int m_dc [NI], m_done [NI], m_err [NI], m_steps [NI];

  typedef struct {
    logic rs, st, l, m, r;
    int   mv, row, col, hdg, dc, done, err;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_u(input string tag, input int i, input int mv, input int row,
                       input int col, input int hdg, input int dc, input int done,
                       input int err);
    logic [18:0] v;
    v = obs_v[i];
    chk($sformatf("%s u%0d move", tag, i), v[18:16], mv);
    chk($sformatf("%s u%0d row", tag, i), v[15:12], row);
    chk($sformatf("%s u%0d col", tag, i), v[11:8], col);
    chk($sformatf("%s u%0d heading", tag, i), v[7:6], hdg);
    chk($sformatf("%s u%0d deadend", tag, i), v[5:2], dc);
    chk($sformatf("%s u%0d done", tag, i), v[1], done);
    chk($sformatf("%s u%0d err", tag, i), v[0], err);
  endtask

  // Reference walk: heading/position as plain integers, sensors resolved by hand rule.
  task automatic model_step(input int i);
    int pref, opp, cmd, tr, tc;
    if (rst) begin
      m_ph[i] = MP_IDLE; m_mv[i] = 0; m_row[i] = P_SR[i]; m_col[i] = P_SC[i];
      m_hdg[i] = P_SH[i]; m_dc[i] = 0; m_done[i] = 0; m_err[i] = 0; m_steps[i] = 0;
      return;
    end
    case (m_ph[i])
      MP_IDLE: begin
        m_mv[i] = 0;
        if (start_d) m_ph[i] = MP_DEC;
      end
      MP_DEC, MP_TURN: begin
        pref = P_HAND[i] != 0 ? int'(r_d) : int'(l_d);
        opp  = P_HAND[i] != 0 ? int'(l_d) : int'(r_d);
        if (m_ph[i] == MP_TURN) cmd = 1;
        else if (pref == 0)     cmd = P_HAND[i] != 0 ? 3 : 2;
        else if (m_d == 1'b0)   cmd = 1;
        else if (opp == 0)      cmd = P_HAND[i] != 0 ? 2 : 3;
        else                    cmd = 4;
        if (cmd == 1) begin
          tr = m_row[i] + DR[m_hdg[i]];
          tc = m_col[i] + DC[m_hdg[i]];
          if (tr < 0 || tr > 8 || tc < 0 || tc > 8) begin
            m_mv[i] = 0; m_err[i] = 1; m_ph[i] = MP_ERR;
          end else begin
            m_mv[i] = 1; m_row[i] = tr; m_col[i] = tc; m_steps[i]++;
            if (tr == 4 && tc == 8)          m_ph[i] = MP_EXIT;
            else if (m_steps[i] >= P_MAX[i]) m_ph[i] = MP_ERR;
            else                             m_ph[i] = MP_DEC;
          end
        end else begin
          m_mv[i] = cmd;
          m_hdg[i] = (m_hdg[i] + (cmd == 2 ? 3 : (cmd == 3 ? 1 : 2))) % 4;
          if (cmd == 4 && m_dc[i] < DC_SAT) m_dc[i]++;
          m_ph[i] = MP_TURN;
        end
      end
      MP_EXIT: begin m_mv[i] = 0; m_done[i] = 1; end
      default: begin m_mv[i] = 0; m_err[i] = 1; end
    endcase
  endtask

  task automatic set_in(input logic rs, input logic st, input logic l, input logic m, input logic r);
    rst = rs; start_d = st; l_d = l; m_d = m; r_d = r;
  endtask

  task automatic tick(input string tag);
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      chk_u(tag, i, m_mv[i], m_row[i], m_col[i], m_hdg[i], m_dc[i], m_done[i], m_err[i]);
  endtask

  initial begin
    // Directed table on the default instance: turns, dead end, reset, corridor to exit.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 4, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 3, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 3, 0, 2, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4, 0, 2, 1, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 0, 1, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 0, 1, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4, 0, 1, 0, 0, 0};
    for (int k = 1; k <= 8; k++)
      tbl[8 + k] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 4, k, 1, 0, 0, 0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4, 8, 1, 0, 1, 0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 8, 1, 0, 1, 0};

    for (int k = 0; k < 19; k++) begin
      set_in(tbl[k].rs, tbl[k].st, tbl[k].l, tbl[k].m, tbl[k].r);
      tick($sformatf("tbl%0d", k));
      chk_u($sformatf("vec%0d", k), 0, tbl[k].mv, tbl[k].row, tbl[k].col, tbl[k].hdg,
            tbl[k].dc, tbl[k].done, tbl[k].err);
    end

    // Right-hand preference next to left-hand preference on open sensors.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick("hand_rst");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick("hand_go");
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick("hand_turn");
    chk_u("hand1_turn", 1, 3, 4, 0, 2, 0, 0, 0);
    chk_u("hand0_turn", 0, 2, 4, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); tick("hand_fwd");
    chk_u("hand1_fwd", 1, 1, 5, 0, 2, 0, 0, 0);
    chk_u("hand0_fwd", 0, 1, 3, 0, 0, 0, 0, 0);

    // Off-grid at the north edge, watchdog expiry, then reset mid-run.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick("wd_rst");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick("wd_go");
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick("wd_f1");
    chk_u("offgrid", 2, 0, 0, 0, 0, 0, 0, 1);
    chk_u("corr_f1", 0, 1, 4, 1, 1, 0, 0, 0);
    for (int k = 2; k <= 5; k++) tick($sformatf("wd_f%0d", k));
    chk_u("wd_last_fwd", 3, 1, 4, 5, 1, 0, 0, 0);
    tick("wd_expire");
    chk_u("wd_stop", 3, 0, 4, 5, 1, 0, 0, 1);
    chk_u("offgrid_frozen", 2, 0, 0, 0, 0, 0, 0, 1);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick("midrun_rst");
    chk_u("midrun_rst", 0, 0, 4, 0, 1, 0, 0, 0);
    chk_u("wd_cleared", 3, 0, 4, 0, 1, 0, 0, 0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick("restart_wait");
    tick("restart_wait2");
    chk_u("needs_start", 0, 0, 4, 0, 1, 0, 0, 0);

    // Repeated dead ends bouncing between col 1 and col 0: count saturates.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick("de_rst");
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick("de_go");
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick("de_first");
    for (int k = 0; k < 16; k++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); tick($sformatf("de_uturn%0d", k));
      set_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      tick($sformatf("de_fwd%0d", k));
    end
    chk_u("deadend_sat", 0, 1, 4, 1, 1, 15, 0, 0);

    // Random sensor episodes with occasional reset.
    for (int ep = 0; ep < 30; ep++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick($sformatf("ep%0d_rst", ep));
      for (int c = 0; c < 40; c++) begin
        set_in(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)));
        tick($sformatf("ep%0d_c%0d", ep, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
